// File: rtl/mem_loader_ctrl_if.sv
// mem_loader_ctrl_if: bus bundle for mem_loader_ctrl.
//   CPU port     : cpu_addr, cpu_we, cpu_din -> cpu_dout, cpu_rdy
//   Command port : cmd_valid/cmd_ready, cmd_op, cmd_base, cmd_len, cmd_fill
//   LOAD stream  : in_valid/in_ready, in_data
//   DUMP stream  : out_valid/out_ready, out_data, out_last
//   Status       : busy, done, csum
// Modports: slave (controller side), master (driver side).
interface mem_loader_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic                  cpu_rdy;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] cmd_fill;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic [15:0]           csum;

  modport slave (
    input  cpu_addr, cpu_we, cpu_din, cmd_valid, cmd_op, cmd_base, cmd_len,
           cmd_fill, in_valid, in_data, out_ready,
    output cpu_dout, cpu_rdy, cmd_ready, in_ready, out_valid, out_data,
           out_last, busy, done, csum
  );

  modport master (
    output cpu_addr, cpu_we, cpu_din, cmd_valid, cmd_op, cmd_base, cmd_len,
           cmd_fill, in_valid, in_data, out_ready,
    input  cpu_dout, cpu_rdy, cmd_ready, in_ready, out_valid, out_data,
           out_last, busy, done, csum
  );
endinterface

// File: rtl/mem_loader_ctrl.sv
// mem_loader_ctrl: memory owner with a CPU bus port and a command-driven
// streaming port (LOAD / FILL / DUMP). The CPU is stalled (cpu_rdy low)
// whenever a command is in progress.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_loader_ctrl_if.slave (CPU, command, LOAD, DUMP, status)
// Optional: define MEM_LOADER_CSUM_EN for the 16-bit running checksum on
// bus.csum; otherwise csum is tied to zero.
module mem_loader_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_loader_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FILL, S_DUMP_RD, S_DUMP_OUT, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_DUMP = 2'b10, OP_FILL = 2'b11
  } op_t;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AINC   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] cpu_dout_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cmd_acc;
  logic                  in_hs;
  logic                  out_hs;
  logic [LEN_WIDTH-1:0]  len_clamped;
  op_t                   op;

  assign op          = op_t'(bus.cmd_op);
  assign cmd_acc     = bus.cmd_valid && (state_q == S_IDLE);
  assign in_hs       = bus.in_valid && (state_q == S_LOAD);
  assign out_hs      = bus.out_ready && (state_q == S_DUMP_OUT);
  assign len_clamped = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;

  // Single write port shared by the CPU (IDLE only), LOAD and FILL.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = fill_q;
    unique case (state_q)
      S_IDLE: begin
        mem_we    = bus.cpu_we;
        mem_waddr = bus.cpu_addr;
        mem_wdata = bus.cpu_din;
        if (cmd_acc) begin
          ptr_d  = bus.cmd_base;
          cnt_d  = len_clamped;
          fill_d = bus.cmd_fill;
          if (op == OP_NOP || len_clamped == '0) begin
            state_d = S_FIN;
          end else begin
            unique case (op)
              OP_LOAD: state_d = S_LOAD;
              OP_FILL: state_d = S_FILL;
              default: state_d = S_DUMP_RD;
            endcase
          end
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          mem_we    = 1'b1;
          mem_wdata = bus.in_data;
          ptr_d     = ptr_q + AINC;
          cnt_d     = cnt_q - ONE;
          if (cnt_q == ONE) state_d = S_FIN;
        end
      end
      S_FILL: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + AINC;
        cnt_d  = cnt_q - ONE;
        if (cnt_q == ONE) state_d = S_FIN;
      end
      S_DUMP_RD: state_d = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (out_hs) begin
          ptr_d   = ptr_q + AINC;
          cnt_d   = cnt_q - ONE;
          state_d = (cnt_q == ONE) ? S_FIN : S_DUMP_RD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      fill_q     <= '0;
      cpu_dout_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      // Read-before-write: same-cycle write to the read address returns old data.
      if (state_q == S_IDLE)    cpu_dout_q <= mem_q[bus.cpu_addr];
      if (state_q == S_DUMP_RD) out_data_q <= mem_q[ptr_q];
    end
  end

  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.cpu_rdy   = (state_q == S_IDLE);
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_DUMP_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = (state_q == S_DUMP_OUT) && (cnt_q == ONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FIN);

`ifdef MEM_LOADER_CSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (cmd_acc) begin
      csum_d = '0;
    end else if (mem_we && state_q != S_IDLE) begin
      csum_d = csum_q + 16'(mem_wdata);
    end else if (out_hs) begin
      csum_d = csum_q + 16'(out_data_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign bus.csum = csum_q;
`else
  assign bus.csum = '0;
`endif

endmodule

// File: tb/tb_mem_loader_ctrl.sv
`timescale 1ns/1ps
module tb_mem_loader_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 17;

`ifdef MEM_LOADER_CSUM_EN
  localparam logic [15:0] CS_LOAD = 16'h000A;
  localparam logic [15:0] CS_FILL = 16'h03A8;
  localparam logic [15:0] CS_DUMP = 16'h000A;
`else
  localparam logic [15:0] CS_LOAD = 16'h0000;
  localparam logic [15:0] CS_FILL = 16'h0000;
  localparam logic [15:0] CS_DUMP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_loader_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  mem_loader_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] q_cpu[$];
  logic [8:0] q_dump[$];   // {last, data}
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: pops expected CPU read data and DUMP words as the DUT presents them.
  initial begin : monitor
    logic [8:0] head;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (q_cpu.size() == 0) fail_now("cpu_rd_underflow");
        else check("cpu_dout", 32'(bus.cpu_dout), 32'(q_cpu.pop_front()));
      end
      rd_pend = rd_req;
      if (bus.done) done_cnt++;
      if (bus.out_valid) begin
        if (q_dump.size() == 0) begin
          fail_now("dump_unexpected");
        end else begin
          head = q_dump[0];
          check("dump_data", 32'(bus.out_data), 32'(head[7:0]));
          check("dump_last", 32'(bus.out_last), 32'(head[8]));
          if (bus.out_ready) void'(q_dump.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_acc(input logic [15:0] a, input logic we, input logic [7:0] d,
                         input logic rd, input logic [7:0] exp);
    bus.cpu_addr = a;
    bus.cpu_we   = we;
    bus.cpu_din  = d;
    if (rd) q_cpu.push_back(exp);
    rd_req = rd;
    tick();
    bus.cpu_we = 1'b0;
    rd_req     = 1'b0;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [15:0] base,
                           input logic [16:0] len, input logic [7:0] fill);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    bus.cmd_fill  = fill;
    while (!bus.cmd_ready && n < 100) begin tick(); n++; end
    if (!bus.cmd_ready) fail_now("cmd_accept_timeout");
    else tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!bus.done && k < 200) begin tick(); k++; end
    if (!bus.done) fail_now("done_timeout");
  endtask

  task automatic feed_word(input logic [7:0] d);
    int n = 0;
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    if (!bus.in_ready) fail_now("in_ready_timeout");
    else tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin : stim
    int k;
    int d0;
    int n;
    bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_din = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_base = '0;
    bus.cmd_len = '0; bus.cmd_fill = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_cpu_dout",  32'(bus.cpu_dout), 0);
    check("rst_cpu_rdy",   32'(bus.cpu_rdy), 1);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_in_ready",  32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data), 0);
    check("rst_out_last",  32'(bus.out_last), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_done",      32'(bus.done), 0);
    check("rst_csum",      32'(bus.csum), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // CPU write/read, read-during-write returns old data
    cpu_acc(16'h0200, 1'b1, 8'hA9, 1'b0, 8'h00);
    check("cpu_rdy_idle", 32'(bus.cpu_rdy), 1);
    cpu_acc(16'h0200, 1'b0, 8'h00, 1'b1, 8'hA9);
    cpu_acc(16'h0201, 1'b1, 8'h5A, 1'b0, 8'h00);
    cpu_acc(16'h0201, 1'b1, 8'h6B, 1'b1, 8'h5A);
    cpu_acc(16'h0201, 1'b0, 8'h00, 1'b1, 8'h6B);
    check("cpu_rdy_idle2", 32'(bus.cpu_rdy), 1);

    // LOAD 0x8000 x4, in_valid every other cycle
    d0 = done_cnt;
    issue_cmd(2'b01, 16'h8000, 17'd4, 8'h00);
    check("load_busy", 32'(bus.busy), 1);
    check("load_cpu_rdy", 32'(bus.cpu_rdy), 0);
    check("load_in_ready", 32'(bus.in_ready), 1);
    for (int i = 1; i <= 4; i++) feed_word(8'(i));
    wait_done(k);
    check("load_fin_in_ready", 32'(bus.in_ready), 0);
    check("load_fin_cmd_ready", 32'(bus.cmd_ready), 0);
    tick();
    check("load_busy_after", 32'(bus.busy), 0);
    check("load_done_low", 32'(bus.done), 0);
    tick(); tick();
    check("load_done_count", 32'(done_cnt - d0), 1);
    check("load_csum", 32'(bus.csum), 32'(CS_LOAD));

    // FILL with address wrap
    issue_cmd(2'b11, 16'hFFFE, 17'd4, 8'hEA);
    wait_done(k);
    check("fill_latency", 32'(k), 4);
    tick();
    check("fill_csum", 32'(bus.csum), 32'(CS_FILL));
    cpu_acc(16'hFFFE, 1'b0, 8'h00, 1'b1, 8'hEA);
    cpu_acc(16'hFFFF, 1'b0, 8'h00, 1'b1, 8'hEA);
    cpu_acc(16'h0000, 1'b0, 8'h00, 1'b1, 8'hEA);
    cpu_acc(16'h0001, 1'b0, 8'h00, 1'b1, 8'hEA);
    cpu_acc(16'h0002, 1'b0, 8'h00, 1'b0, 8'h00);

    // DUMP 0x8000 x4, stall 3 cycles on word 2
    for (int i = 1; i <= 4; i++) q_dump.push_back({(i == 4) ? 1'b1 : 1'b0, 8'(i)});
    issue_cmd(2'b10, 16'h8000, 17'd4, 8'h00);
    for (int w = 0; w < 4; w++) begin
      n = 0;
      while (!bus.out_valid && n < 50) begin tick(); n++; end
      if (!bus.out_valid) fail_now("out_valid_timeout");
      if (w == 1) repeat (3) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    wait_done(k);
    tick();
    check("dump_q_empty", 32'(q_dump.size()), 0);
    check("dump_csum", 32'(bus.csum), 32'(CS_DUMP));

    // CPU write ignored and pending command held off during LOAD; then len=0
    cpu_acc(16'h0300, 1'b1, 8'h11, 1'b0, 8'h00);
    d0 = done_cnt;
    issue_cmd(2'b01, 16'h9000, 17'd2, 8'h00);
    bus.cpu_addr = 16'h0300; bus.cpu_we = 1'b1; bus.cpu_din = 8'h77;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_base = 16'h0300;
    bus.cmd_len = 17'd0;
    check("busy_cpu_rdy", 32'(bus.cpu_rdy), 0);
    check("busy_cmd_ready", 32'(bus.cmd_ready), 0);
    tick();
    bus.cpu_we = 1'b0;
    feed_word(8'hC1);
    feed_word(8'hC2);
    check("fin_cmd_ready", 32'(bus.cmd_ready), 0);
    check("fin_done", 32'(bus.done), 1);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin tick(); n++; end
    check("pend_after_done", 32'(done_cnt - d0), 1);
    tick();
    bus.cmd_valid = 1'b0;
    check("len0_done", 32'(bus.done), 1);
    tick();
    check("len0_done_low", 32'(bus.done), 0);
    check("len0_idle", 32'(bus.cmd_ready), 1);
    check("len0_done_count", 32'(done_cnt - d0), 2);
    cpu_acc(16'h0300, 1'b0, 8'h00, 1'b1, 8'h11);
    cpu_acc(16'h9000, 1'b0, 8'h00, 1'b1, 8'hC1);
    cpu_acc(16'h9001, 1'b0, 8'h00, 1'b1, 8'hC2);

    // Reset after 2 of 4 LOAD words
    issue_cmd(2'b11, 16'h4000, 17'd4, 8'h55);
    wait_done(k);
    tick();
    issue_cmd(2'b01, 16'h4000, 17'd4, 8'h00);
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    tick();
    bus.in_data = 8'hBB;
    tick();
    bus.in_valid = 1'b0;
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("mid_rst_cpu_rdy", 32'(bus.cpu_rdy), 1);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_done", 32'(done_cnt - d0), 0);
    check("mid_rst_cmd_ready2", 32'(bus.cmd_ready), 1);
    check("mid_rst_csum", 32'(bus.csum), 0);
    cpu_acc(16'h4000, 1'b0, 8'h00, 1'b1, 8'hAA);
    cpu_acc(16'h4001, 1'b0, 8'h00, 1'b1, 8'hBB);
    cpu_acc(16'h4002, 1'b0, 8'h00, 1'b1, 8'h55);
    cpu_acc(16'h4003, 1'b0, 8'h00, 1'b1, 8'h55);
    tick();
    tick();
    check("cpu_q_empty", 32'(q_cpu.size()), 0);
    check("dump_q_empty_end", 32'(q_dump.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
